pixfetch_ctrl: RTL and testbench

Fetch scheduler for the VGA pixel path. It runs the Wishbone read master that fills the pixel FIFO from frame memory, one line at a time. Reads are issued in bounded bursts whenever the FIFO drops below half full. Line addresses advance by a programmable stride, and the block restarts at the frame base on each frame-start pulse. It sits between the system Wishbone bus and the pixel FIFO; the pixel-clock side only pops.

---
 rtl/pixfetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pixfetch_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixfetch_ctrl.sv
// pixfetch_ctrl -- fetch scheduler for the VGA pixel path.
//
// Runs the Wishbone read master that fills the pixel FIFO from frame memory,
// one line at a time. Reads go out in bursts of at most BURST acks whenever
// the FIFO is below half full. Line start addresses advance by i_stride, and
// a frame-start pulse restarts the frame at i_base_addr.
//
// Optional feature macro: PIXFETCH_ERR_EN builds the sticky o_err logic
// (overflow push, or a frame start while a frame is in flight). Without it
// o_err is tied low.
//
// Handshake: o_wb_cyc/o_wb_stb rise together and stay high with a stable
// o_wb_addr until i_wb_ack; every ack seen while cyc is high transfers one
// word (pushed into the FIFO the same cycle unless a frame start masks it).
// Acks while cyc is low are ignored.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_enable              fetch enable
//   i_frame_start         one-cycle pulse, restart the frame (needs i_enable)
//   i_base_addr           byte address of line 0 (word aligned)
//   i_stride              byte distance between line starts (word aligned)
//   i_fifo_half/full      FIFO level flags
//   o_fifo_push           push bus data into the FIFO this cycle
//   o_fifo_flush          one-cycle FIFO clear on an accepted frame start
//   o_wb_addr/sel/cyc/stb Wishbone read master outputs, i_wb_ack input
//   o_line_done           pulse the cycle after the last word of a line
//   o_busy                high in WAIT or REQ
//   o_err                 sticky error flag (PIXFETCH_ERR_EN only)
//   o_dbg_state           FSM state: 0 IDLE, 1 WAIT, 2 REQ, 3 DONE
module pixfetch_ctrl #(
  parameter int WORDS_PER_LINE = 160,
  parameter int LINES          = 480,
  parameter int BURST          = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_frame_start,
  input  logic [31:0] i_base_addr,
  input  logic [15:0] i_stride,
  input  logic        i_fifo_half,
  input  logic        i_fifo_full,
  output logic        o_fifo_push,
  output logic        o_fifo_flush,
  output logic [31:0] o_wb_addr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic        i_wb_ack,
  output logic        o_line_done,
  output logic        o_busy,
  output logic        o_err,
  output logic [1:0]  o_dbg_state
);

  localparam int WW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [WW-1:0] LAST_WORD  = WW'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0] LAST_LINE  = LW'(LINES - 1);
  localparam logic [BW-1:0] LAST_BURST = BW'(BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [31:0]   line_addr;
  logic [WW-1:0] word_cnt;
  logic [LW-1:0] line_cnt;
  logic [BW-1:0] burst_cnt;

  logic start;
  logic last_word;
  logic last_line;
  logic burst_end;

  // A frame start is only honoured while enabled.
  assign start     = i_frame_start & i_enable;
  assign last_word = (word_cnt == LAST_WORD);
  assign last_line = (line_cnt == LAST_LINE);
  assign burst_end = (burst_cnt == LAST_BURST);

  // The ack of a restarted transfer is dropped: its data belongs to the old frame.
  assign o_fifo_push  = i_wb_ack & (state == S_REQ) & ~i_frame_start;
  assign o_fifo_flush = start;
  assign o_wb_sel     = 4'hF;
  assign o_wb_stb     = o_wb_cyc;
  assign o_busy       = (state == S_WAIT) | (state == S_REQ);
  assign o_dbg_state  = state;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      line_addr   <= '0;
      word_cnt    <= '0;
      line_cnt    <= '0;
      burst_cnt   <= '0;
      o_wb_addr   <= '0;
      o_wb_cyc    <= 1'b0;
      o_line_done <= 1'b0;
    end else begin
      o_line_done <= 1'b0;
      if (start) begin
        state     <= S_WAIT;
        line_addr <= i_base_addr;
        o_wb_addr <= i_base_addr;
        word_cnt  <= '0;
        line_cnt  <= '0;
        burst_cnt <= '0;
        o_wb_cyc  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_WAIT: begin
            if (i_enable && !i_fifo_half) begin
              state     <= S_REQ;
              burst_cnt <= '0;
              o_wb_cyc  <= 1'b1;
            end else if (!i_enable) begin
              state <= S_IDLE;
            end
          end
          S_REQ: begin
            // Without an ack the request is held, even with i_enable low.
            if (i_wb_ack) begin
              burst_cnt <= burst_end ? '0 : burst_cnt + 1'b1;
              // o_wb_addr tracks line_addr + 4*word_cnt incrementally.
              if (last_word) begin
                line_addr   <= line_addr + {16'h0000, i_stride};
                o_wb_addr   <= line_addr + {16'h0000, i_stride};
                word_cnt    <= '0;
                line_cnt    <= last_line ? '0 : line_cnt + 1'b1;
                o_line_done <= 1'b1;
              end else begin
                word_cnt  <= word_cnt + 1'b1;
                o_wb_addr <= o_wb_addr + 32'd4;
              end
              if (last_word && last_line) begin
                state    <= S_DONE;
                o_wb_cyc <= 1'b0;
              end else if (burst_end || i_fifo_full || !i_enable) begin
                state    <= S_WAIT;
                o_wb_cyc <= 1'b0;
              end
            end
          end
          S_DONE: ;
          default: begin
            state    <= S_IDLE;
            o_wb_cyc <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PIXFETCH_ERR_EN
  logic err_q;

  // Overflow: a word pushed into a full FIFO. Short frame: restart mid-frame.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      err_q <= 1'b0;
    end else if ((o_fifo_push && i_fifo_full) || (start && o_busy)) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixfetch_ctrl.sv
// Testbench for pixfetch_ctrl: directed scenarios plus randomized frames.
// A frame-level reference model lists every word address of a frame in
// exp_q when a frame start is issued; a monitor pops and compares on every
// FIFO push.
module tb_pixfetch_ctrl;
  localparam int W = 4;
  localparam int L = 2;
  localparam int B = 3;

`ifdef PIXFETCH_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        fs;
  logic [31:0] base;
  logic [15:0] stride;
  logic        half;
  logic        full;
  logic        ack;
  logic        push;
  logic        flush;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        line_done;
  logic        busy;
  logic        err;
  logic [1:0]  st;

  pixfetch_ctrl #(
    .WORDS_PER_LINE(W),
    .LINES(L),
    .BURST(B)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_enable(en),
    .i_frame_start(fs),
    .i_base_addr(base),
    .i_stride(stride),
    .i_fifo_half(half),
    .i_fifo_full(full),
    .o_fifo_push(push),
    .o_fifo_flush(flush),
    .o_wb_addr(addr),
    .o_wb_sel(sel),
    .o_wb_cyc(cyc),
    .o_wb_stb(stb),
    .i_wb_ack(ack),
    .o_line_done(line_done),
    .o_busy(busy),
    .o_err(err),
    .o_dbg_state(st)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int frame_idx = 0;
  bit ld_next = 1'b0;
  int ld_count = 0;
  int tenure_len = 0;
  int last_tenure = 0;
  bit cyc_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every word of a frame, in fetch order.
  task automatic model_frame(input logic [31:0] b, input logic [15:0] s);
    exp_q.delete();
    frame_idx = 0;
    for (int l = 0; l < L; l++)
      for (int w = 0; w < W; w++)
        exp_q.push_back(b + 32'(l) * {16'h0000, s} + 32'(4 * w));
  endtask

  task automatic reset_model();
    exp_q.delete();
    frame_idx = 0;
    ld_next = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] exp_w;
    forever begin
      @(negedge clk);
      #2;
      check("stb_eq_cyc", stb, cyc);
      check("sel", sel, 4'hF);
      check("flush", flush, fs & en);
      check("push_rule", push, ack & cyc & ~fs);
      check("line_done", line_done, ld_next);
      if (line_done) ld_count++;
      ld_next = 1'b0;
      if (push) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL push_extra: actual push at %0h, required no push", addr);
        end else begin
          exp_w = exp_q.pop_front();
          check("push_addr", addr, exp_w);
        end
        ld_next = ((frame_idx % W) == W - 1);
        frame_idx++;
        tenure_len++;
      end
      if (cyc_prev && !cyc) begin
        last_tenure = tenure_len;
        n_cmp++;
        if (tenure_len > B) begin
          n_err++;
          $display("FAIL burst_max: actual %0d acks, required at most %0d", tenure_len, B);
        end
      end
      if (!cyc) tenure_len = 0;
      cyc_prev = cyc;
`ifndef PIXFETCH_ERR_EN
      check("err_off", err, 1'b0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [31:0] b, input logic [15:0] s);
    @(negedge clk);
    en = 1'b1;
    fs = 1'b1;
    base = b;
    stride = s;
    ack = 1'b0;
    model_frame(b, s);
    @(negedge clk);
    fs = 1'b0;
  endtask

  task automatic wait_cyc(input int budget);
    int k;
    k = 0;
    while (!cyc && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("cyc_reached", cyc, 1'b1);
  endtask

  // Slave acks every cycle while cyc is high.
  task automatic run_until_done(input int budget);
    int k;
    k = 0;
    while (st != 2'd3 && k < budget) begin
      @(negedge clk);
      ack = cyc;
      k++;
    end
    check("done_reached", 32'(st == 2'd3), 1);
    ack = 1'b0;
  endtask

  task automatic drive_rand();
    logic [31:0] b;
    logic [15:0] s;
    fs = 1'b0;
    ack = cyc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
    half = ($urandom_range(0, 3) == 0);
    full = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 99) == 0) begin
      b = $urandom & 32'hFFFF_FFFC;
      s = 16'($urandom) & 16'hFFFC;
      fs = 1'b1;
      base = b;
      stride = s;
      model_frame(b, s);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int ld0;
    logic [31:0] b;
    logic [15:0] s;
    rst_n = 1'b1;
    en = 1'b0;
    fs = 1'b0;
    half = 1'b0;
    full = 1'b0;
    ack = 1'b0;
    base = '0;
    stride = '0;
    #1 rst_n = 1'b0;

    // Reset values
    @(negedge clk);
    #3;
    check("rst_cyc", cyc, 1'b0);
    check("rst_addr", addr, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", st, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame with start latency
    half = 1'b0;
    ld0 = ld_count;
    start_frame(32'h1000, 16'h0100);
    #3;
    check("lat_wait_state", st, 2'd1);
    check("lat_wait_cyc", cyc, 1'b0);
    @(negedge clk);
    ack = cyc;
    #3;
    check("lat_req_cyc", cyc, 1'b1);
    check("lat_req_addr", addr, 32'h1000);
    run_until_done(100);
    @(negedge clk);
    #3;
    check("frame_line_done_cnt", ld_count - ld0, L);
    check("frame_busy", busy, 1'b0);
    check("frame_state", st, 2'd3);
    check("frame_drained", exp_q.size(), 0);
    check("frame_err", err, 1'b0);

    // FIFO throttle, then burst limit
    half = 1'b1;
    start_frame(32'h2000, 16'h0040);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      check("throttle_no_cyc", cyc, 1'b0);
    end
    @(negedge clk);
    half = 1'b0;
    #3;
    check("throttle_release_cyc", cyc, 1'b0);
    @(negedge clk);
    ack = cyc;
    #3;
    check("throttle_cyc", cyc, 1'b1);
    check("throttle_addr", addr, 32'h2000);
    k = 0;
    do begin
      @(negedge clk);
      half = 1'b1;
      ack = cyc;
      k++;
    end while (cyc && k < 10);
    #3;
    check("burst_len", last_tenure, B);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      check("burst_hold_no_cyc", cyc, 1'b0);
    end
    @(negedge clk);
    half = 1'b0;
    wait_cyc(10);
    #3;
    check("burst_resume_addr", addr, 32'h2000 + 4 * B);
    run_until_done(100);

    // Overflow push
    full = 1'b1;
    start_frame(32'h6000, 16'h0010);
    wait_cyc(10);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #3;
    check("err_overflow", err, ERR_EXP);
    check("full_end_cyc", cyc, 1'b0);
    check("full_end_state", st, 2'd1);
    full = 1'b0;
    run_until_done(100);
    check("err_sticky", err, ERR_EXP);

    // Frame restart coincident with an ack
    start_frame(32'h3000, 16'h0080);
    wait_cyc(10);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b1;
    fs = 1'b1;
    base = 32'h4000;
    stride = 16'h0010;
    model_frame(32'h4000, 16'h0010);
    #3;
    check("restart_no_push", push, 1'b0);
    check("restart_flush", flush, 1'b1);
    @(negedge clk);
    fs = 1'b0;
    ack = 1'b0;
    #3;
    check("restart_cyc_low", cyc, 1'b0);
    check("restart_state", st, 2'd1);
    @(negedge clk);
    #3;
    check("restart_cyc", cyc, 1'b1);
    check("restart_addr", addr, 32'h4000);
    run_until_done(100);

    // Enable dropped during REQ
    start_frame(32'h5000, 16'h0040);
    wait_cyc(10);
    en = 1'b0;
    ack = 1'b0;
    @(negedge clk);
    fs = 1'b1;
    base = 32'h9999_0000;
    #3;
    check("en_low_hold_cyc", cyc, 1'b1);
    @(negedge clk);
    fs = 1'b0;
    ack = 1'b1;
    #3;
    check("en_low_pending_push", push, 1'b1);
    @(negedge clk);
    ack = 1'b0;
    #3;
    check("en_low_wait", st, 2'd1);
    check("en_low_cyc", cyc, 1'b0);
    @(negedge clk);
    #3;
    check("en_low_idle", st, 2'd0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      check("idle_no_cyc", cyc, 1'b0);
    end

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hFC))
                                      : ($urandom & 32'hFFFF_FFFC);
      s = 16'($urandom) & 16'hFFFC;
      half = 1'b0;
      full = 1'b0;
      start_frame(b, s);
      k = 0;
      while (st != 2'd3 && k < 600) begin
        @(negedge clk);
        drive_rand();
        k++;
      end
      check("rand_done", 32'(st == 2'd3), 1);
      @(negedge clk);
      fs = 1'b0;
      ack = 1'b0;
      #3;
      check("rand_drained", exp_q.size(), 0);
    end

    // Reset mid-burst
    half = 1'b0;
    full = 1'b0;
    start_frame(32'h7000, 16'h0020);
    wait_cyc(10);
    ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    reset_model();
    #3;
    check("mid_rst_cyc", cyc, 1'b0);
    check("mid_rst_stb", stb, 1'b0);
    check("mid_rst_addr", addr, 32'h0);
    check("mid_rst_push", push, 1'b0);
    check("mid_rst_line_done", line_done, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_sel", sel, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #3;
      check("post_rst_idle", st, 2'd0);
      check("post_rst_no_cyc", cyc, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
